// File: rtl/cam_capture_565.sv
// cam_capture_565: OV7670-style byte stream to RGB565 pixel write strobes.
// Optional colour-bar test pattern is built when CAM_TEST_PATTERN_EN is defined.
module cam_capture_565 #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              wclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              test_mode,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_din,
  output logic [ADDR_W-1:0] cam_addr,
  output logic [15:0]       cam_data,
  output logic              cam_we,
  output logic              busy,
  output logic              frame_done,
  output logic              short_frame,
  output logic [ADDR_W:0]   pixel_count
);

  localparam int TOTAL_I = H_PIXELS * V_LINES;
  localparam logic [ADDR_W:0] TOTAL = (ADDR_W+1)'(TOTAL_I);
  localparam int CW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_FRAME,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [2:0] pclk_q, vs_q, href_q;
  logic [7:0] din1_q, din2_q;

  logic [ADDR_W:0]   pix_q, pix_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     line_q, line_d;
  logic              ph_q, ph_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              we_q, we_d;
  logic              short_q, short_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic pclk_rise, vs_rise, vs_fall, href_fall;
  logic byte_ok, in_window;
  logic [15:0] pix_data;

  // Two-flop synchronizers plus an edge-detect stage; data aligned with pclk stage 2.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      pclk_q <= '0;
      vs_q   <= '0;
      href_q <= '0;
      din1_q <= '0;
      din2_q <= '0;
    end else begin
      pclk_q <= {pclk_q[1:0], cam_pclk};
      vs_q   <= {vs_q[1:0], cam_vsync};
      href_q <= {href_q[1:0], cam_href};
      din1_q <= cam_din;
      din2_q <= din1_q;
    end
  end

  assign pclk_rise = pclk_q[1] & ~pclk_q[2];
  assign vs_rise   = vs_q[1] & ~vs_q[2];
  assign vs_fall   = ~vs_q[1] & vs_q[2];
  assign href_fall = ~href_q[1] & href_q[2];
  assign byte_ok   = pclk_rise & href_q[1];
  assign in_window = (col_q < CW'(H_PIXELS)) &&
                     (line_q < CW'(V_LINES)) &&
                     (pix_q < TOTAL);

`ifdef CAM_TEST_PATTERN_EN
  localparam int BAR_W = H_PIXELS / 8;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    unique case (idx)
      3'd0: c = 16'hFFFF;
      3'd1: c = 16'hFFE0;
      3'd2: c = 16'h07FF;
      3'd3: c = 16'h07E0;
      3'd4: c = 16'hF81F;
      3'd5: c = 16'hF800;
      3'd6: c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // Pixel value: camera pair, or the colour bar for this column in test mode.
  always_comb begin
    pix_data = {hi_q, din2_q};
    if (test_mode)
      pix_data = bar_color(3'(col_q / CW'(BAR_W)));
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign pix_data = {hi_q, din2_q};
`endif

  // State and datapath registers.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      col_q   <= '0;
      line_q  <= '0;
      ph_q    <= 1'b0;
      hi_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      short_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      col_q   <= col_d;
      line_q  <= line_d;
      ph_q    <= ph_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      short_q <= short_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: frame sequencing, byte pairing and line/frame boundaries.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    col_d   = col_q;
    line_d  = line_q;
    ph_d    = ph_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    short_d = short_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (enable)
          state_d = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (vs_fall) begin
          pix_d   = '0;
          col_d   = '0;
          line_d  = '0;
          ph_d    = 1'b0;
          short_d = 1'b0;
          cnt_d   = '0;
          addr_d  = '0;
          state_d = S_FRAME;
        end
      end
      S_FRAME: begin
        if (vs_rise || (pix_q == TOTAL)) begin
          cnt_d   = pix_q;
          short_d = (pix_q < TOTAL);
          state_d = S_DONE;
        end else if (byte_ok) begin
          if (!ph_q) begin
            hi_d = din2_q;
            ph_d = 1'b1;
          end else begin
            ph_d = 1'b0;
            if (col_q != '1)
              col_d = col_q + CW'(1);
            if (in_window) begin
              we_d   = 1'b1;
              addr_d = pix_q[ADDR_W-1:0];
              data_d = pix_data;
              pix_d  = pix_q + (ADDR_W+1)'(1);
            end
          end
        end else if (href_fall) begin
          col_d = '0;
          ph_d  = 1'b0;
          if (line_q != '1)
            line_d = line_q + CW'(1);
        end
      end
      S_DONE: begin
        if (enable) begin
          state_d = S_WAIT_FRAME;
        end else begin
          state_d = S_IDLE;
          addr_d  = '0;
        end
      end
    endcase
  end

  assign cam_addr    = addr_q;
  assign cam_data    = data_q;
  assign cam_we      = we_q;
  assign busy        = (state_q == S_WAIT_FRAME) || (state_q == S_FRAME);
  assign frame_done  = (state_q == S_DONE);
  assign short_frame = short_q;
  assign pixel_count = cnt_q;

endmodule

// File: tb/tb_cam_capture_565.sv
// tb_cam_capture_565: randomized camera frames against a queue-based model.
// Reduced frame geometry keeps the run short.
module tb_cam_capture_565;

  localparam int H   = 16;
  localparam int V   = 6;
  localparam int AW  = 7;
  localparam int TOT = H * V;

  logic          wclk = 1'b0;
  logic          rst;
  logic          enable;
  logic          test_mode;
  logic          pclk;
  logic          vsync;
  logic          href;
  logic [7:0]    din;
  logic [AW-1:0] cam_addr;
  logic [15:0]   cam_data;
  logic          cam_we;
  logic          busy;
  logic          frame_done;
  logic          short_frame;
  logic [AW:0]   pixel_count;

  cam_capture_565 #(
    .H_PIXELS(H),
    .V_LINES (V),
    .ADDR_W  (AW)
  ) dut (
    .wclk       (wclk),
    .rst        (rst),
    .enable     (enable),
    .test_mode  (test_mode),
    .cam_pclk   (pclk),
    .cam_vsync  (vsync),
    .cam_href   (href),
    .cam_din    (din),
    .cam_addr   (cam_addr),
    .cam_data   (cam_data),
    .cam_we     (cam_we),
    .busy       (busy),
    .frame_done (frame_done),
    .short_frame(short_frame),
    .pixel_count(pixel_count)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  typedef struct packed {
    logic [AW:0] n;
    logic        s;
  } sum_t;

  wr_t  exp_wr[$];
  sum_t exp_sum[$];

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;

  logic [AW-1:0] last_addr;
  logic [15:0]   last_data;
  logic [AW-1:0] addr_of_1000;
  logic [AW-1:0] first_addr;
  bit            watch_first = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // Compare every output-meaningful cycle against the model queues.
  always @(negedge wclk) begin
    wr_t  e;
    sum_t s;
    if (rst !== 1'b1) begin
      if (cam_we) begin
        n_chk++;
        if (exp_wr.size() == 0) begin
          $display("FAIL unexpected_we: got strobe addr %0d data 0x%0h, required none",
                   cam_addr, cam_data);
        end else begin
          n_pass++;
          e = exp_wr.pop_front();
          check("wr_addr", 32'(cam_addr), 32'(e.a));
          check("wr_data", 32'(cam_data), 32'(e.d));
        end
        last_addr = cam_addr;
        last_data = cam_data;
        if (cam_data == 16'd1000) addr_of_1000 = cam_addr;
        if (watch_first) begin
          first_addr  = cam_addr;
          watch_first = 1'b0;
        end
      end
      if (frame_done) begin
        n_done++;
        check("done_busy", 32'(busy), 32'd0);
        n_chk++;
        if (exp_sum.size() == 0) begin
          $display("FAIL unexpected_done: got frame_done count %0d, required none",
                   pixel_count);
        end else begin
          n_pass++;
          s = exp_sum.pop_front();
          check("pixel_count", 32'(pixel_count), 32'(s.n));
          check("short_frame", 32'(short_frame), 32'(s.s));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge wclk);
  endtask

  task automatic pclk_period(input logic [7:0] b);
    @(negedge wclk);
    pclk = 1'b0;
    din  = b;
    @(negedge wclk);
    @(negedge wclk);
    pclk = 1'b1;
    @(negedge wclk);
  endtask

  task automatic idle(input int n);
    repeat (n) pclk_period(8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  32'(cam_addr),    32'd0);
    check({tag, "_data"},  32'(cam_data),    32'd0);
    check({tag, "_we"},    32'(cam_we),      32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_done"},  32'(frame_done),  32'd0);
    check({tag, "_short"}, 32'(short_frame), 32'd0);
    check({tag, "_count"}, 32'(pixel_count), 32'd0);
  endtask

  // One camera frame. len<0 picks a random byte count per line.
  // mode 0: random bytes, 1: pair k=l*H+p, 2: pair k=l*1000+p.
  task automatic frame(input int nl, input int len, input int mode,
                       input bit cap_in, input int en_l, input int dis_l,
                       input int rst_l);
    bit          cap;
    bit          ended;
    int          pix;
    int          n;
    int          p;
    logic [15:0] kk;
    logic [7:0]  hi;
    logic [7:0]  b;
    logic [15:0] ed;
    wr_t         w;
    sum_t        s;
    cap   = cap_in;
    ended = 1'b0;
    pix   = 0;
    hi    = '0;
    test_mode = 1'($urandom_range(0, 1));
    vsync = 1'b1;
    idle(8);
    vsync = 1'b0;
    idle(3);
    for (int l = 0; l < nl; l++) begin
      if (l == en_l)  enable = 1'b1;
      if (l == dis_l) enable = 1'b0;
      n = (len < 0) ? $urandom_range(0, 2 * H + 5) : len;
      href = 1'b1;
      cyc(2);
      for (int bi = 0; bi < n; bi++) begin
        p  = bi / 2;
        kk = (mode == 1) ? 16'(l * H + p) : 16'(l * 1000 + p);
        if (mode == 0)    b = 8'($urandom);
        else if (bi % 2) b = kk[7:0];
        else             b = kk[15:8];
        if (bi % 2 == 0) begin
          hi = b;
        end else if (cap && !ended && p < H && l < V) begin
          ed = {hi, b};
`ifdef CAM_TEST_PATTERN_EN
          if (test_mode) ed = bars[p / (H / 8)];
`endif
          w.a = AW'(pix);
          w.d = ed;
          exp_wr.push_back(w);
          pix++;
          if (pix == TOT) begin
            ended = 1'b1;
            s.n = (AW+1)'(TOT);
            s.s = 1'b0;
            exp_sum.push_back(s);
          end
        end
        pclk_period(b);
      end
      cyc(1);
      href = 1'b0;
      idle(3);
      if (l == rst_l) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        cyc(2);
        rst = 1'b0;
        cap = 1'b0;
        watch_first = 1'b1;
      end
    end
    if (cap && !ended) begin
      s.n = (AW+1)'(pix);
      s.s = (pix < TOT);
      exp_sum.push_back(s);
    end
    vsync = 1'b1;
    idle(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    test_mode = 1'b0;
    pclk      = 1'b0;
    vsync     = 1'b0;
    href      = 1'b0;
    din       = '0;
    cyc(3);
    #1;
    check_reset_outputs("por");
    @(negedge wclk);
    rst = 1'b0;
    cyc(2);

    // enable low: nothing captured
    frame(V, 2 * H, 1, 1'b0, -1, -1, -1);
    check("idle_busy", 32'(busy), 32'd0);

    // enable raised mid-frame: this frame ignored, waiting afterwards
    frame(V, 2 * H, 0, 1'b0, 2, -1, -1);
    check("late_en_busy", 32'(busy), 32'd1);

    // full frame with counting pairs
    frame(V, 2 * H, 1, 1'b1, -1, -1, -1);
    check("full_last_addr", 32'(last_addr), 32'd95);
    check("full_last_data", 32'(last_data), 32'd95);
    check("full_count_held", 32'(pixel_count), 32'd96);
    check("full_short", 32'(short_frame), 32'd0);

    // long lines with an odd trailing byte
    frame(V, 2 * H + 21, 2, 1'b1, -1, -1, -1);
    check("long_line1_start", 32'(addr_of_1000), 32'd16);
    check("long_last_data", 32'(last_data), 32'd5015);

    // short frame: three lines then vsync
    frame(3, 2 * H, 1, 1'b1, -1, -1, -1);
    check("short_count", 32'(pixel_count), 32'd48);
    check("short_flag", 32'(short_frame), 32'd1);

    // random line lengths and line counts
    repeat (4) frame(V - 2 + $urandom_range(0, 4), -1, 0, 1'b1, -1, -1, -1);

    // enable dropped mid-frame: frame still completes, then idle
    frame(V, -1, 0, 1'b1, -1, 1, -1);
    frame(V, 2 * H, 0, 1'b0, -1, -1, -1);
    check("dis_busy", 32'(busy), 32'd0);

    // reset after line 0, then next frame restarts at address 0
    enable = 1'b1;
    cyc(4);
    check("rearm_busy", 32'(busy), 32'd1);
    frame(V, 2 * H, 0, 1'b1, -1, -1, 0);
    frame(V, 2 * H, 0, 1'b1, -1, -1, -1);
    check("post_rst_first_addr", 32'(first_addr), 32'd0);

    idle(10);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("sum_queue_empty", 32'(exp_sum.size()), 32'd0);
    check("frames_done", 32'(n_done), 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cam_capture_565.md
Name: cam_capture_565

Overview:
- Camera front-end that sits directly upstream of the SRAM image writer.
- Samples an OV7670-style 8-bit parallel stream (pclk, vsync, href, d[7:0]) in the system clock domain and pairs bytes into RGB565 pixels.
- Emits each pixel as a one-cycle write strobe with a linear frame address (cam_addr / cam_data / cam_we), which the SRAM writer consumes unchanged.
- Addresses start at 0 on every frame, so the writer's "wait for address 0" start condition holds.

Parameters:
- H_PIXELS, 320, pixels kept per line.
- V_LINES, 240, lines kept per frame.
- ADDR_W, 17, width of cam_addr and pixel_count; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES.

Ports:
- wclk  in  1  system clock; must be at least 4x the camera pclk.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  arm capture of the next full frame; sampled only in S_IDLE.
- test_mode  in  1  select internal test pattern; effective only with CAM_TEST_PATTERN_EN.
- cam_pclk  in  1  camera pixel clock, treated as data.
- cam_vsync  in  1  frame sync, active-high.
- cam_href  in  1  line valid, active-high.
- cam_din  in  8  camera byte.
- cam_addr  out  ADDR_W  address of the current pixel.
- cam_data  out  16  RGB565 pixel.
- cam_we  out  1  one-cycle pixel-valid strobe.
- busy  out  1  high in S_WAIT_FRAME and S_FRAME.
- frame_done  out  1  one-cycle pulse at frame end.
- short_frame  out  1  set at frame end if fewer than H_PIXELS*V_LINES pixels were written; held until the next frame starts.
- pixel_count  out  ADDR_W+1  number of pixels written in the last frame; held until the next frame starts.

Behaviour:
- Reset (asynchronous):
  - All outputs 0.
  - Synchronizers, counters and byte phase cleared.
  - State S_IDLE.
- Input sampling:
  - cam_pclk, cam_vsync, cam_href and cam_din pass through a 2-FF synchronizer, plus a third stage for edge detection.
  - pclk_rise = sync2 & ~sync3. Data is taken from the same pipeline stage as pclk_rise.
  - vsync_fall and vsync_rise are detected the same way; href_fall likewise.
- S_IDLE:
  - cam_addr held at 0; pixel counter and column counter are not reset here.
  - enable=1 -> S_WAIT_FRAME.
- S_WAIT_FRAME:
  - All bytes ignored.
  - On vsync_fall: clear pixel counter, column counter, line counter, byte phase, short_frame and pixel_count; go to S_FRAME.
  - Entering mid-frame therefore always waits for the next full frame.
- S_FRAME, byte handling:
  - A valid byte is pclk_rise with href (synchronized) = 1.
  - Phase 0: latch the byte as the high byte; set phase to 1.
  - Phase 1: if column < H_PIXELS and line < V_LINES, then next cycle cam_data={hi, byte}, cam_addr=pixel counter, cam_we=1 for exactly one wclk. Then increment pixel counter. Column increments regardless. Set phase to 0.
  - Excess pixels in a line, and lines beyond V_LINES, are dropped: no cam_we, no address change.
- S_FRAME, line and frame boundaries:
  - href_fall: column=0, phase=0, line+1. A dangling odd byte is discarded.
  - Frame end -> S_DONE on whichever comes first: vsync_rise, or the pixel counter reaching H_PIXELS*V_LINES after the final write.
  - If both occur in the same cycle, a single frame end is taken.
- S_DONE (one cycle):
  - frame_done=1; pixel_count=pixel counter; short_frame=(pixel counter < H_PIXELS*V_LINES).
  - Next state: S_WAIT_FRAME if enable=1 (continuous capture), else S_IDLE.
- Between strobes:
  - cam_addr and cam_data hold their last value.
  - cam_addr returns to 0 on entry to S_IDLE and on vsync_fall.
- Control changes and reset:
  - enable deassertion during S_WAIT_FRAME or S_FRAME has no effect until S_DONE.
  - Reset mid-frame aborts immediately; no frame_done is produced.
- Arithmetic: the pixel counter is ADDR_W+1 bits and never wraps. The last address issued is H_PIXELS*V_LINES-1 (76799 at defaults).

Optional Feature:
- Macro: CAM_TEST_PATTERN_EN.
- Defined, with test_mode=1: timing, strobes and addresses are still driven by the camera, but cam_data is replaced by 8 vertical colour bars by column/(H_PIXELS/8).
  - Bar order: 0xFFFF, 0xFFE0, 0x07FF, 0x07E0, 0xF81F, 0xF800, 0x001F, 0x0000.
- Defined, with test_mode=0: normal capture.
- Not defined: test_mode is ignored, no pattern logic is synthesized, and behaviour is identical to test_mode=0.

Test Plan:
- Full frame: enable=1, model sends 240 lines of 640 bytes, byte pair k = {k[15:8], k[7:0]} -> 76800 cam_we pulses; addresses 0..76799 in order; cam_data=k at address k; frame_done pulse; pixel_count=76800; short_frame=0.
- Short frame: vsync rises after 10 lines -> 3200 writes, pixel_count=3200, short_frame=1, frame_done once.
- Long line plus odd byte: lines of 661 bytes -> exactly 320 writes per line; addresses contiguous across lines (line 1 starts at 320); odd byte discarded.
- Late enable: enable asserted mid-frame -> no cam_we until the next vsync falling edge; first write has cam_addr=0.
- Reset mid-frame: rst pulsed after 1000 pixels -> all outputs 0 immediately; no frame_done; the next enabled frame starts at address 0.
- Pattern (CAM_TEST_PATTERN_EN defined, test_mode=1): column 0 -> 0xFFFF, column 40 -> 0xFFE0, column 319 -> 0x0000; addresses identical to normal capture.
